// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD, streams frame bytes,
// checks CRC-32 and length, and counts good/bad frames.
// Ports:
//   clk, I_rst        : rx clock, synchronous active-high reset
//   I_rxd, I_rxdv     : GMII receive byte and data valid
//   O_data, O_valid   : frame byte stream (DA through FCS)
//   O_sof, O_eof      : first/last byte markers, qualified by O_valid
//   O_crc_ok, O_len_err, O_len : frame status on the O_eof beat
//   O_good_cnt, O_bad_cnt      : wrapping frame counters
module gmii_rx_frame_parser #(
  parameter int PRE_MIN = 1,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        I_rst,
  input  logic [7:0]  I_rxd,
  input  logic        I_rxdv,
  output logic [7:0]  O_data,
  output logic        O_valid,
  output logic        O_sof,
  output logic        O_eof,
  output logic        O_crc_ok,
  output logic        O_len_err,
  output logic [15:0] O_len,
  output logic [15:0] O_good_cnt,
  output logic [15:0] O_bad_cnt
);

  localparam logic [2:0]  PMIN    = 3'(PRE_MIN);
  localparam logic [15:0] MINL    = 16'(MIN_LEN);
  localparam logic [15:0] MAXL    = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_pre_cnt;
  logic [2:0]  w_pre_cnt_nxt;
  logic        w_sfd;

  logic [7:0]  r_hold;
  logic        r_hold_v;
  logic        r_hold_sof;
  logic        r_first;
  logic [15:0] r_len;
  logic [31:0] r_crc;

  logic        w_cap;
  logic        w_end;
  logic        w_len_err;
  logic [31:0] w_crc_nxt;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ 32'hEDB88320;
      else             x = x >> 1;
    end
    return x;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_sfd         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (I_rxdv) begin
          if (I_rxd == 8'h55) begin
            w_state_nxt   = S_PRE;
            w_pre_cnt_nxt = 3'd1;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!I_rxdv) begin
          w_state_nxt = S_IDLE;
        end else if (I_rxd == 8'h55) begin
          if (r_pre_cnt != 3'd7) w_pre_cnt_nxt = r_pre_cnt + 3'd1;
        end else if (I_rxd == 8'hD5 && r_pre_cnt >= PMIN) begin
          w_state_nxt = S_DATA;
          w_sfd       = 1'b1;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_DATA: if (!I_rxdv) w_state_nxt = S_IDLE;
      S_DROP: if (!I_rxdv) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Coming out of reset in the middle of a burst must not lock onto it.
  always_ff @(posedge clk) begin
    if (I_rst) begin
      r_state   <= I_rxdv ? S_DROP : S_IDLE;
      r_pre_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
    end
  end

  assign w_cap     = (r_state == S_DATA) && I_rxdv;
  // The held byte is the last one when rxdv has already dropped.
  assign w_end     = r_hold_v && !I_rxdv;
  assign w_crc_nxt = crc_byte(r_crc, r_hold);
  assign w_len_err = (r_len < MINL) || (r_len > MAXL);

  always_ff @(posedge clk) begin
    if (I_rst) begin
      r_hold     <= 8'h00;
      r_hold_v   <= 1'b0;
      r_hold_sof <= 1'b0;
      r_first    <= 1'b0;
      r_len      <= 16'h0000;
      r_crc      <= 32'hFFFFFFFF;
      O_data     <= 8'h00;
      O_valid    <= 1'b0;
      O_sof      <= 1'b0;
      O_eof      <= 1'b0;
      O_crc_ok   <= 1'b0;
      O_len_err  <= 1'b0;
      O_len      <= 16'h0000;
      O_good_cnt <= 16'h0000;
      O_bad_cnt  <= 16'h0000;
    end else begin
      r_hold_v <= w_cap;
      if (w_cap) begin
        r_hold     <= I_rxd;
        r_hold_sof <= r_first;
        r_first    <= 1'b0;
        if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
      end
      // CRC trails capture by one byte so the compare sees the final byte.
      if (w_sfd) begin
        r_first <= 1'b1;
        r_len   <= 16'h0000;
        r_crc   <= 32'hFFFFFFFF;
      end else if (r_hold_v) begin
        r_crc <= w_crc_nxt;
      end
      O_valid   <= r_hold_v;
      O_data    <= r_hold;
      O_sof     <= r_hold_v && r_hold_sof;
      O_eof     <= w_end;
      O_crc_ok  <= w_end && (w_crc_nxt == RESIDUE);
      O_len_err <= w_end && w_len_err;
      if (w_end) O_len <= r_len;
      if (O_valid && O_eof) begin
        if (O_crc_ok && !O_len_err) O_good_cnt <= O_good_cnt + 16'd1;
        else                        O_bad_cnt  <= O_bad_cnt + 16'd1;
      end
    end
  end

endmodule
